// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register ahead of the 32-bit ALU; decodes ALUctl and selects operand B.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpressure: single-entry; in_ready = !flush && (!out_valid || out_ready), so full throughput.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             upstream handshake
//   alu_op, funct, rs_data, rt_data, imm, alu_src   decoded instruction fields
//   flush                           kills the held entry and blocks the offered one
//   out_valid / out_ready           downstream handshake
//   ALUctl, A, B, illegal           registered ALU control, operands and unsupported-op flag
//   issue_count                     (only with ALU_ISSUE_PERF_CNT_EN) saturating count of legal consumes
//
// Optional feature macro: ALU_ISSUE_PERF_CNT_EN
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              alu_src,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ALUctl,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
`ifdef ALU_ISSUE_PERF_CNT_EN
  output logic [31:0]       issue_count,
`endif
  output logic              illegal
);

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;
  // Code 15 forces the ALU output to zero, so an unsupported op is harmless downstream.
  localparam logic [3:0] CTL_BAD = 4'd15;

  logic              accept;
  logic [3:0]        dec_ctl;
  logic              dec_illegal;
  logic [DATA_W-1:0] b_sel;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ctl     = CTL_BAD;
    dec_illegal = 1'b1;
    case (alu_op)
      2'b00: begin dec_ctl = CTL_ADD; dec_illegal = 1'b0; end
      2'b01: begin dec_ctl = CTL_SUB; dec_illegal = 1'b0; end
      2'b10: begin
        dec_illegal = 1'b0;
        case (funct)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b100111: dec_ctl = CTL_NOR;
          6'b101010: dec_ctl = CTL_SLT;
          default: begin dec_ctl = CTL_BAD; dec_illegal = 1'b1; end
        endcase
      end
      default: begin dec_ctl = CTL_BAD; dec_illegal = 1'b1; end
    endcase
  end

  assign b_sel = alu_src ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : rt_data;

  // Flush wins over accept and hold; it clears only the valid and illegal flags so the
  // data registers never change without an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      ALUctl    <= '0;
      A         <= '0;
      B         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      illegal   <= dec_illegal;
      ALUctl    <= dec_ctl;
      A         <= rs_data;
      B         <= b_sel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_PERF_CNT_EN
  // Counts every handshake completion of a legal entry; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count <= '0;
    end else if (out_valid && out_ready && !illegal && (issue_count != 32'hFFFF_FFFF)) begin
      issue_count <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        alu_src;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic        illegal;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] issue_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_op(alu_op),
    .funct(funct),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .imm(imm),
    .alu_src(alu_src),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUctl(ALUctl),
    .A(A),
    .B(B),
`ifdef ALU_ISSUE_PERF_CNT_EN
    .issue_count(issue_count),
`endif
    .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im, input logic src);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
    rs_data  = rs;
    rt_data  = rt;
    imm      = im;
    alu_src  = src;
  endtask

  logic [5:0] fn_tab  [6];
  logic [3:0] ctl_tab [6];

  initial begin
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    ctl_tab = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    alu_op = 2'b00; funct = '0; rs_data = '0; rt_data = '0; imm = '0; alu_src = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ALUctl", ALUctl, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // R-type add
    out_ready = 1'b1;
    offer(2'b10, 6'b100000, 32'd5, 32'd7, 16'h0000, 1'b0);
    step();
    in_valid = 1'b0;
    chk("add_out_valid", out_valid, 1);
    chk("add_ALUctl", ALUctl, 2);
    chk("add_A", A, 5);
    chk("add_B", B, 7);
    chk("add_illegal", illegal, 0);
    step();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_A_kept", A, 5);

    // Immediate sign extension
    offer(2'b00, 6'b000000, 32'd100, 32'd9, 16'hFFFC, 1'b1);
    step();
    in_valid = 1'b0;
    chk("imm_B", B, 32'hFFFF_FFFC);
    chk("imm_ALUctl", ALUctl, 2);
    chk("imm_A", A, 100);
    step();

    // All legal funct codes back to back
    for (int i = 0; i < 6; i++) begin
      offer(2'b10, fn_tab[i], 32'd10 + i, 32'd20, 16'h0, 1'b0);
      step();
      chk($sformatf("funct%0d_valid", i), out_valid, 1);
      chk($sformatf("funct%0d_ctl", i), ALUctl, ctl_tab[i]);
      chk($sformatf("funct%0d_A", i), A, 32'd10 + i);
    end
    in_valid = 1'b0;
    step();

    // Illegal decodes still flow through
    offer(2'b10, 6'b000000, 32'd1, 32'd2, 16'h0, 1'b0);
    step();
    chk("ill_funct_valid", out_valid, 1);
    chk("ill_funct_ctl", ALUctl, 15);
    chk("ill_funct_flag", illegal, 1);
    offer(2'b11, 6'b100000, 32'd1, 32'd2, 16'h0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ill_op_valid", out_valid, 1);
    chk("ill_op_ctl", ALUctl, 15);
    chk("ill_op_flag", illegal, 1);
    step();

    // Backpressure
    out_ready = 1'b0;
    offer(2'b01, 6'b0, 32'd9, 32'd3, 16'h0, 1'b0);
    step();
    chk("bp_first_valid", out_valid, 1);
    offer(2'b10, 6'b100100, 32'hAA, 32'h55, 16'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
      chk($sformatf("bp%0d_ctl", c), ALUctl, 6);
      chk($sformatf("bp%0d_A", c), A, 9);
      chk($sformatf("bp%0d_B", c), B, 3);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_ctl", ALUctl, 0);
    chk("bp_second_A", A, 32'hAA);
    chk("bp_second_B", B, 32'h55);
    step();

    // Flush while holding an illegal entry, with a new one offered
    out_ready = 1'b0;
    offer(2'b11, 6'b0, 32'd1, 32'd2, 16'h0, 1'b0);
    step();
    chk("fl_held_illegal", illegal, 1);
    offer(2'b01, 6'b0, 32'd77, 32'd78, 16'h0, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_illegal", illegal, 0);
    chk("fl_A_kept", A, 1);
    chk("fl_ctl_kept", ALUctl, 15);

    // Asynchronous reset while holding
    offer(2'b00, 6'b0, 32'd33, 32'd44, 16'h0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_A", A, 0);
    chk("ar_ctl", ALUctl, 0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    chk("ar_count", issue_count, 0);
`endif
    step();
    rst_n = 1'b1;

    // 4 legal + 1 illegal consumes
    out_ready = 1'b1;
    offer(2'b00, 6'b0, 32'd1, 32'd1, 16'h0, 1'b0); step();
    offer(2'b01, 6'b0, 32'd2, 32'd1, 16'h0, 1'b0); step();
    offer(2'b11, 6'b0, 32'd3, 32'd1, 16'h0, 1'b0); step();
    chk("pc_illegal_held", illegal, 1);
    offer(2'b10, 6'b100101, 32'd4, 32'd1, 16'h0, 1'b0); step();
    offer(2'b10, 6'b101010, 32'd5, 32'd1, 16'h0, 1'b0); step();
    in_valid = 1'b0;
    chk("pc_last_ctl", ALUctl, 7);
    step();
    chk("pc_drained", out_valid, 0);
    step();
`ifdef ALU_ISSUE_PERF_CNT_EN
    chk("pc_count", issue_count, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
